// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the watchdog counter sizing helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Watchdog counter is at least 8 bits and wide enough to hold the timeout.
  function automatic int unsigned miss_cnt_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage operand forwarding comparator for one source operand.
// MEM result beats WB data; x0 is never forwarded.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] dst_mem,
  input  logic       we_mem,
  input  logic [4:0] dst_wb,
  input  logic       we_wb,
  output logic [1:0] sel
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = FWD_RF;
    if (src != REG_ZERO) begin
      if (we_mem && (dst_mem == src)) begin
        sel = FWD_MEM;
      end else if (we_wb && (dst_wb == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: bubbles, flushes,
// forwarding selects, miss-stall FSM with watchdog. Optional performance
// counters are built when HAZARD_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       reg1_srcD,
  input  logic [4:0]       reg2_srcD,
  input  logic [4:0]       reg1_srcE,
  input  logic [4:0]       reg2_srcE,
  input  logic [4:0]       reg_dstE,
  input  logic [4:0]       reg_dstM,
  input  logic [4:0]       reg_dstW,
  input  logic             reg_write_en_EX,
  input  logic             reg_write_en_MEM,
  input  logic             reg_write_en_WB,
  input  logic             wb_select_EX,
  input  logic             br_EX,
  input  logic             jalr_EX,
  input  logic             jal_ID,
  input  logic             miss,
  output logic             bubbleF,
  output logic             bubbleD,
  output logic             bubbleE,
  output logic             bubbleM,
  output logic             bubbleW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       op1_sel,
  output logic [1:0]       op2_sel,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] miss_cycles
);

  localparam int unsigned MC_W = miss_cnt_width(MISS_TIMEOUT);
  localparam logic [MC_W-1:0] TIMEOUT_CNT = MC_W'(MISS_TIMEOUT);

  logic [1:0] op1_fwd;
  logic [1:0] op2_fwd;

  fwd_unit u_fwd_op1 (
    .src     (reg1_srcE),
    .dst_mem (reg_dstM),
    .we_mem  (reg_write_en_MEM),
    .dst_wb  (reg_dstW),
    .we_wb   (reg_write_en_WB),
    .sel     (op1_fwd)
  );

  fwd_unit u_fwd_op2 (
    .src     (reg2_srcE),
    .dst_mem (reg_dstM),
    .we_mem  (reg_write_en_MEM),
    .dst_wb  (reg_dstW),
    .we_wb   (reg_write_en_WB),
    .sel     (op2_fwd)
  );

  assign op1_sel = rst_n ? op1_fwd : FWD_RF;
  assign op2_sel = rst_n ? op2_fwd : FWD_RF;

  logic ctrl_ex;
  logic load_use;

  assign ctrl_ex  = br_EX | jalr_EX;
  assign load_use = wb_select_EX && reg_write_en_EX && (reg_dstE != REG_ZERO) &&
                    ((reg_dstE == reg1_srcD) || (reg_dstE == reg2_srcD));

  // Reset clears every segment; a miss freezes everything and masks the rest.
  always_comb begin
    {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = '0;
    {flushF, flushD, flushE, flushM, flushW}      = '0;
    if (!rst_n) begin
      {flushF, flushD, flushE, flushM, flushW} = '1;
    end else if (miss) begin
      {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = '1;
    end else if (ctrl_ex) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (jal_ID) begin
      flushD = 1'b1;
    end else if (load_use) begin
      bubbleF = 1'b1;
      bubbleD = 1'b1;
      flushE  = 1'b1;
    end
  end

  state_e          state_q, state_d;
  logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;
  logic            miss_timeout_q, miss_timeout_d;

  always_comb begin
    state_d        = state_q;
    miss_cnt_d     = miss_cnt_q;
    miss_timeout_d = miss_timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        miss_cnt_d = '0;
        if (miss) state_d = ST_MISS;
      end
      ST_MISS: begin
        if (miss) begin
          if (miss_cnt_q < TIMEOUT_CNT) miss_cnt_d = miss_cnt_q + MC_W'(1);
        end else begin
          state_d    = ST_IDLE;
          miss_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        miss_cnt_d = '0;
      end
    endcase
    if (miss_cnt_d == TIMEOUT_CNT) miss_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      miss_cnt_q     <= '0;
      miss_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      miss_cnt_q     <= miss_cnt_d;
      miss_timeout_q <= miss_timeout_d;
    end
  end

  assign miss_timeout = miss_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;
  logic [CNT_W-1:0] miss_cycles_q, miss_cycles_d;
  logic             flush_ev;

  // flushD outside reset and miss can only come from br/jalr/jal.
  assign flush_ev = flushD && rst_n && !miss;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    miss_cycles_d  = miss_cycles_q;
    if (bubbleF && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (flush_ev && (flush_events_q != '1)) flush_events_d = flush_events_q + CNT_W'(1);
    if (miss && (miss_cycles_q != '1)) miss_cycles_d = miss_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
      miss_cycles_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
      miss_cycles_q  <= miss_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
  assign miss_cycles  = miss_cycles_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
  assign miss_cycles  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected output vectors are queued when
// stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE;
  logic [4:0] reg_dstE, reg_dstM, reg_dstW;
  logic reg_write_en_EX, reg_write_en_MEM, reg_write_en_WB;
  logic wb_select_EX, br_EX, jalr_EX, jal_ID, miss;
  logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic [1:0] op1_sel, op2_sel;
  logic miss_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events, miss_cycles;

  pipe_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reg1_srcD        (reg1_srcD),
    .reg2_srcD        (reg2_srcD),
    .reg1_srcE        (reg1_srcE),
    .reg2_srcE        (reg2_srcE),
    .reg_dstE         (reg_dstE),
    .reg_dstM         (reg_dstM),
    .reg_dstW         (reg_dstW),
    .reg_write_en_EX  (reg_write_en_EX),
    .reg_write_en_MEM (reg_write_en_MEM),
    .reg_write_en_WB  (reg_write_en_WB),
    .wb_select_EX     (wb_select_EX),
    .br_EX            (br_EX),
    .jalr_EX          (jalr_EX),
    .jal_ID           (jal_ID),
    .miss             (miss),
    .bubbleF          (bubbleF),
    .bubbleD          (bubbleD),
    .bubbleE          (bubbleE),
    .bubbleM          (bubbleM),
    .bubbleW          (bubbleW),
    .flushF           (flushF),
    .flushD           (flushD),
    .flushE           (flushE),
    .flushM           (flushM),
    .flushW           (flushW),
    .op1_sel          (op1_sel),
    .op2_sel          (op2_sel),
    .miss_timeout     (miss_timeout),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events),
    .miss_cycles      (miss_cycles)
  );

  // bub/fl are ordered {F, D, E, M, W}.
  typedef struct packed {
    logic [4:0] bub;
    logic [4:0] fl;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       to;
  } out_t;

  out_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
  int unsigned exp_miss  = 0;

  function automatic out_t mk(input logic [4:0] bub, input logic [4:0] fl,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic to);
    out_t r;
    r.bub = bub;
    r.fl  = fl;
    r.s1  = s1;
    r.s2  = s2;
    r.to  = to;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; sample on the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input out_t e);
    out_t o;
    out_t x;
    exp_q.push_back(e);
    @(negedge clk);
    o = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
         flushF, flushD, flushE, flushM, flushW,
         op1_sel, op2_sel, miss_timeout};
    x = exp_q.pop_front();
    check(tag, 64'(o), 64'(x));
    check({tag, "_stall_cnt"}, 64'(stall_cycles), 64'(exp_stall));
    check({tag, "_flush_cnt"}, 64'(flush_events), 64'(exp_flush));
    check({tag, "_miss_cnt"},  64'(miss_cycles),  64'(exp_miss));
    if (!rst_n) begin
      exp_stall = 0;
      exp_flush = 0;
      exp_miss  = 0;
    end else begin
`ifdef HAZARD_PERF_CNT_EN
      if (x.bub != 5'b0)     exp_stall++;
      if (x.bub == 5'b11111) exp_miss++;
      if (x.fl[3])           exp_flush++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  localparam out_t IDLE = '0;
  localparam out_t RST  = '{bub: 5'b0, fl: 5'b11111, s1: 2'b00, s2: 2'b00, to: 1'b0};

  initial begin
    rst_n = 1'b0;
    {reg1_srcD, reg2_srcD, reg1_srcE, reg2_srcE, reg_dstE, reg_dstM, reg_dstW} = '0;
    {reg_write_en_EX, reg_write_en_MEM, reg_write_en_WB} = '0;
    {wb_select_EX, br_EX, jalr_EX, jal_ID, miss} = '0;
    @(posedge clk);
    #1;

    // Reset held with live forwarding matches: selects must still read 00.
    reg1_srcE = 5'd5; reg_dstM = 5'd5; reg_write_en_MEM = 1'b1;
    reg_dstW = 5'd5; reg_write_en_WB = 1'b1;
    step("rst_a", RST);
    step("rst_b", RST);
    rst_n = 1'b1;

    step("fwd_mem", mk(5'b0, 5'b0, 2'b01, 2'b00, 1'b0));
    reg_write_en_MEM = 1'b0;
    step("fwd_wb", mk(5'b0, 5'b0, 2'b10, 2'b00, 1'b0));
    reg1_srcE = 5'd0; reg_dstM = 5'd0; reg_dstW = 5'd0; reg_write_en_MEM = 1'b1;
    step("fwd_x0", IDLE);
    reg1_srcE = 5'd9; reg2_srcE = 5'd5; reg_dstM = 5'd5; reg_dstW = 5'd9;
    step("fwd_both", mk(5'b0, 5'b0, 2'b10, 2'b01, 1'b0));
    reg_write_en_MEM = 1'b0; reg_write_en_WB = 1'b0; reg1_srcE = 5'd0; reg2_srcE = 5'd0;

    wb_select_EX = 1'b1; reg_write_en_EX = 1'b1; reg_dstE = 5'd7; reg2_srcD = 5'd7;
    step("lu", mk(5'b11000, 5'b00100, 2'b00, 2'b00, 1'b0));
    wb_select_EX = 1'b0;
    step("lu_end", IDLE);
    wb_select_EX = 1'b1; reg_dstE = 5'd0; reg2_srcD = 5'd0;
    step("lu_x0", IDLE);
    reg_dstE = 5'd7; reg2_srcD = 5'd7; br_EX = 1'b1;
    step("lu_br", mk(5'b0, 5'b01100, 2'b00, 2'b00, 1'b0));
    br_EX = 1'b0; jal_ID = 1'b1;
    step("lu_jal", mk(5'b0, 5'b01000, 2'b00, 2'b00, 1'b0));
    wb_select_EX = 1'b0;
    step("jal", mk(5'b0, 5'b01000, 2'b00, 2'b00, 1'b0));
    jalr_EX = 1'b1;
    step("jalr_jal", mk(5'b0, 5'b01100, 2'b00, 2'b00, 1'b0));
    jalr_EX = 1'b0; jal_ID = 1'b0;
    step("ctrl_end", IDLE);

    miss = 1'b1; br_EX = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("miss_br%0d", i), mk(5'b11111, 5'b0, 2'b00, 2'b00, 1'b0));
    miss = 1'b0;
    step("miss_drop_br", mk(5'b0, 5'b01100, 2'b00, 2'b00, 1'b0));
    br_EX = 1'b0;
    step("miss_idle", IDLE);

    // First miss cycle is spent in IDLE; the 4th cycle in MISS is step index 4.
    miss = 1'b1;
    for (int i = 0; i < 10; i++)
      step($sformatf("tmo%0d", i), mk(5'b11111, 5'b0, 2'b00, 2'b00, (i >= 5) ? 1'b1 : 1'b0));
    miss = 1'b0;
    step("tmo_sticky_a", mk(5'b0, 5'b0, 2'b00, 2'b00, 1'b1));
    step("tmo_sticky_b", mk(5'b0, 5'b0, 2'b00, 2'b00, 1'b1));
    rst_n = 1'b0;
    step("tmo_rst_a", mk(5'b0, 5'b11111, 2'b00, 2'b00, 1'b1));
    step("tmo_rst_b", RST);
    rst_n = 1'b1;
    step("tmo_clear", IDLE);

    miss = 1'b1;
    step("mid_miss_a", mk(5'b11111, 5'b0, 2'b00, 2'b00, 1'b0));
    step("mid_miss_b", mk(5'b11111, 5'b0, 2'b00, 2'b00, 1'b0));
    rst_n = 1'b0;
    step("mid_miss_rst", RST);
    rst_n = 1'b1;
    step("mid_miss_rel", mk(5'b11111, 5'b0, 2'b00, 2'b00, 1'b0));
    miss = 1'b0;
    step("mid_miss_end", IDLE);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline. It drives the bubble and flush inputs of every segment register: IF/ID, ID/EX, EX/MEM (Ctrl_MEM and its data partner) and MEM/WB. It also generates the EX-stage operand forwarding selects. A registered state machine tracks data-cache miss stalls, enforces a miss timeout watchdog and, optionally, keeps performance counters.

Parameters:
- MISS_TIMEOUT, 255: consecutive miss-stall cycles before miss_timeout is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset; synchronous, active-low.
- reg1_srcD, reg2_srcD  in  5 each  source registers of the instruction in ID.
- reg1_srcE, reg2_srcE  in  5 each  source registers of the instruction in EX.
- reg_dstE, reg_dstM, reg_dstW  in  5 each  destination registers in EX, MEM and WB.
- reg_write_en_EX, reg_write_en_MEM, reg_write_en_WB  in  1 each  register-write enables per stage.
- wb_select_EX  in  1  1 = the instruction in EX is a load.
- br_EX  in  1  branch taken, resolved in EX.
- jalr_EX  in  1  jalr in EX.
- jal_ID  in  1  jal in ID.
- miss  in  1  data cache miss or busy; the pipeline must freeze.
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1 each  hold the corresponding segment register.
- flushF, flushD, flushE, flushM, flushW  out  1 each  clear the corresponding segment register.
- op1_sel, op2_sel  out  2 each  forwarding select: 00 register file, 01 MEM ALU result, 10 WB data.
- miss_timeout  out  1  sticky watchdog flag.
- stall_cycles, flush_events, miss_cycles  out  CNT_W each  performance counters.

Behaviour:
- Reset (rst_n=0 sampled on a clk edge):
  - State goes to IDLE; miss_cnt, miss_timeout and all counters go to 0.
  - While rst_n=0, all flush* outputs are 1, all bubble* outputs are 0 and op*_sel is 00, so every segment register clears.
- Outputs are combinational from the inputs and the registered state; there is no added latency.
- Priority when several conditions are active (highest first):
  1. Cache-miss stall.
  2. Control flush.
  3. Load-use stall.
- Miss stall: when miss=1, all bubble* outputs are 1 and all flush* outputs are 0 in the same cycle. This overrides any simultaneous br/jal/load-use condition; those re-evaluate when miss drops, because the frozen stages hold their inputs.
- Control flush, applied only when miss=0:
  - br_EX or jalr_EX: flushD=1 and flushE=1. This suppresses load-use.
  - jal_ID alone: flushD=1.
  - br_EX/jalr_EX together with jal_ID: same result as br_EX (the EX redirect wins).
- Load-use, applied only when there is no miss and no control flush:
  - Condition: wb_select_EX, reg_write_en_EX, reg_dstE!=0, and reg_dstE equals reg1_srcD or reg2_srcD.
  - Response: bubbleF=1, bubbleD=1, flushE=1.
- Forwarding, evaluated separately for op1 (using reg1_srcE) and op2 (using reg2_srcE):
  - Source x0 always selects 00.
  - Select 01 if reg_write_en_MEM and reg_dstM matches the source.
  - Else select 10 if reg_write_en_WB and reg_dstW matches the source.
  - Else 00. MEM takes priority over WB.
- FSM, states IDLE and MISS:
  - IDLE to MISS on miss=1.
  - MISS stays in MISS while miss=1; MISS to IDLE on miss=0.
  - miss_cnt (8 bits or more, sized from MISS_TIMEOUT) increments each cycle in MISS while miss=1, saturates at MISS_TIMEOUT, and clears on entry to IDLE.
  - When miss_cnt reaches MISS_TIMEOUT, miss_timeout is set. It stays set until reset. The stall continues regardless.
- Reset mid-miss: the state returns to IDLE and the flags clear. If miss is still 1 after reset is released, the FSM re-enters MISS.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on each cycle with a miss or load-use stall.
  - flush_events increments on each cycle with flushD=1 caused by br/jalr/jal.
  - miss_cycles increments on each cycle with miss=1.
  - All three are saturating and cleared by reset.
- Not defined: all three counter outputs are tied to 0 and no counter flops are built.

Decomposition:
- Shared package (hazard_pkg):
  - Forwarding select encodings: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - FSM state encodings: ST_IDLE, ST_MISS.
  - Register index constant REG_ZERO=5'd0.
- One sub-module is natural: fwd_unit, a combinational forwarding comparator instantiated twice (op1 and op2).

Test Plan:
- Reset: hold rst_n=0 for 2 clocks → all flush*=1, bubble*=0, op*_sel=00. Release reset → all flush* drop to 0 and all counters read 0.
- Forwarding:
  - reg1_srcE=5, reg_dstM=5, reg_write_en_MEM=1, reg_dstW=5, reg_write_en_WB=1 → op1_sel=01.
  - Drop reg_write_en_MEM → op1_sel=10.
  - reg1_srcE=0 with matching destinations → op1_sel=00.
- Load-use: wb_select_EX=1, reg_dstE=7, reg2_srcD=7 → bubbleF=bubbleD=flushE=1 for exactly the one cycle the condition holds. Also assert br_EX=1 → flushD=flushE=1 and bubbleF=0.
- Miss priority: miss=1 for 3 cycles while br_EX=1 → all bubble*=1 and no flush* for those 3 cycles. On the first cycle with miss=0 → flushD=flushE=1, and the FSM returns to IDLE.
- Timeout: MISS_TIMEOUT=4, miss held at 1 for 10 cycles → miss_timeout rises after the 4th cycle in MISS and stays 1 after miss drops, until rst_n=0.
- Counters (with HAZARD_PERF_CNT_EN): 3 miss cycles, 1 load-use cycle and 2 jal_ID cycles → stall_cycles=4, miss_cycles=3, flush_events=2.
